mxn_bits_shift: RTL and testbench
=================================

// Module: mxn_bits_shift
// PURPOSE
//  - SIMD barrel shifter: shifts SETS independent WIDTH-bit lanes of one packed bus.
//  - All lanes use the same direction and amount.
//  - Logical or arithmetic flavour is fixed per instance by parameter OP.
//  - Shift unit of the ALU datapath; output registered, one-cycle latency.
// PARAMETERS
//  - WIDTH  4  bits per lane; also the width of shift_amt
//  - SETS   2  number of lanes packed in in_packed/out_packed
//  - OP     0  0 = logical shift, 1 = arithmetic shift; any other value is treated as 0
// PORTS
//  - clk         in   1           rising-edge clock
//  - rst_n       in   1           asynchronous, active-low reset
//  - in_packed   in   SETS*WIDTH  lane i = in_packed[i*WIDTH +: WIDTH]
//  - shift_dir   in   1           0 = left, 1 = right
//  - shift_amt   in   WIDTH       unsigned shift distance
//  - out_packed  out  SETS*WIDTH  shifted lanes, same lane packing as in_packed
//  - zero_flag   out  SETS        per-lane result==0; present only with MXN_SHIFT_ZERO_FLAG_EN
// BEHAVIOUR
//  - Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
//  - Reset: rst_n low clears out_packed (and zero_flag) to 0 immediately, no clock needed.
//  - Reset is held while low; a reset mid-operation discards the pending result.
//  - Latency: inputs sampled on the rising clk edge; result on out_packed after that edge (1 cycle).
//  - No handshake; a new operation is accepted every cycle.
//  - Lanes are fully independent; no bits cross a lane boundary.
//  - Left shift, both OP values: lane << shift_amt, zero-filled from the LSB.
//  - Right shift, OP=0: lane >> shift_amt, zero-filled from the MSB.
//  - Right shift, OP=1: lane >>> shift_amt, filled with the lane's MSB (sign bit).
//  - shift_amt = 0: lane passes through unchanged.
//  - shift_amt >= WIDTH, left shift or logical right shift: lane = 0.
//  - shift_amt >= WIDTH, arithmetic right shift: lane = {WIDTH{msb}}.
//  - Datapath is combinational from the inputs to the output register D.
//  - out_packed has no combinational path from the inputs.
// CONFIGURATION
//  - MXN_SHIFT_ZERO_FLAG_EN defined:
//    - adds output zero_flag[SETS-1:0], registered alongside out_packed;
//    - zero_flag[i] = 1 iff the next lane i result is 0; reset value 0.
//  - MXN_SHIFT_ZERO_FLAG_EN undefined:
//    - port and logic are absent; shift behaviour is identical.
// STRUCTURE
//  - Package mxn_shift_pkg holds:
//    - OP_LOGICAL=0 and OP_ARITH=1;
//    - DIR_LEFT=0 and DIR_RIGHT=1;
//    - a lane-slice helper function.
//  - One sub-module, nbits_shift_lane: combinational WIDTH-bit shifter (params WIDTH, OP).
//  - The top generate-loops SETS instances of nbits_shift_lane into one output register.
// TESTING  (WIDTH=4, SETS=2, both OP values unless stated; check one clock after applying inputs)
//  - Left shift: lanes {4'b1001,4'b0011}, dir=0, amt=1.
//    -> out {4'b0010,4'b0110}; identical for OP=0 and OP=1.
//  - Right shift: lanes {4'b1000,4'b0110}, dir=1, amt=2.
//    -> OP=0: {4'b0010,4'b0001}.
//    -> OP=1: {4'b1110,4'b0001}.
//  - Boundary amounts:
//    -> amt=0 passes {4'b1011,4'b0101} unchanged.
//    -> amt=5, dir=1, lane 4'b1011: OP=0 gives 4'b0000, OP=1 gives 4'b1111.
//  - Reset: drive rst_n low between clock edges while out_packed is nonzero.
//    -> out_packed is 0 immediately, with no clock edge.
//    -> the first edge after rst_n rises produces the correct result.
//  - Exhaustive sweep, compared against a software model every cycle:
//    -> every lane value 0..15, dir=0 with amt 1..3, dir=1 with amt 1..2.
//  - Zero flag, with MXN_SHIFT_ZERO_FLAG_EN: lanes {4'b1000,4'b0001}, dir=0, amt=1.
//    -> zero_flag = 2'b10 (lane 1 result 0, lane 0 result 4'b0010).

Source files
------------

// File: rtl/mxn_bits_shift_pkg.sv
// Shared constants and helpers for the SIMD barrel shifter (mxn_bits_shift).
// Optional zero-flag output is enabled with the MXN_SHIFT_ZERO_FLAG_EN macro.
package mxn_shift_pkg;

    localparam int OP_LOGICAL = 0;
    localparam int OP_ARITH   = 1;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } shift_dir_e;

    // Bit position of the LSB of a lane inside a packed bus.
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/mxn_bits_shift_if.sv
// Bus interface of mxn_bits_shift; zero_flag exists only with MXN_SHIFT_ZERO_FLAG_EN.
interface mxn_bits_shift_if #(
    parameter int WIDTH = 4,
    parameter int SETS  = 2
);
    logic [SETS*WIDTH-1:0] in_packed;
    logic                  shift_dir;
    logic [WIDTH-1:0]      shift_amt;
    logic [SETS*WIDTH-1:0] out_packed;
`ifdef MXN_SHIFT_ZERO_FLAG_EN
    logic [SETS-1:0]       zero_flag;

    modport master (output in_packed, shift_dir, shift_amt, input out_packed, zero_flag);
    modport slave  (input in_packed, shift_dir, shift_amt, output out_packed, zero_flag);
`else
    modport master (output in_packed, shift_dir, shift_amt, input out_packed);
    modport slave  (input in_packed, shift_dir, shift_amt, output out_packed);
`endif
endinterface

// File: rtl/mxn_bits_shift_lane.sv
// nbits_shift_lane: combinational WIDTH-bit shifter for one lane, logical or arithmetic by OP.
module nbits_shift_lane
    import mxn_shift_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int OP    = 0
) (
    input  logic [WIDTH-1:0] lane,
    input  logic             dir,
    input  logic [WIDTH-1:0] amt,
    output logic [WIDTH-1:0] result
);
    // Any OP other than OP_ARITH behaves as a logical shifter.
    localparam bit IS_ARITH = (OP == OP_ARITH);

    logic signed [WIDTH-1:0] lane_s;
    logic        [WIDTH-1:0] sign_fill;
    logic                    amt_overflow;

    assign lane_s       = lane;
    assign sign_fill    = {WIDTH{IS_ARITH & lane[WIDTH-1]}};
    assign amt_overflow = ({1'b0, amt} >= (WIDTH+1)'(WIDTH));

    always_comb begin
        result = '0;
        if (amt_overflow) begin
            result = (dir == DIR_RIGHT) ? sign_fill : '0;
        end else if (dir == DIR_LEFT) begin
            result = lane << amt;
        end else if (IS_ARITH) begin
            result = lane_s >>> amt;
        end else begin
            result = lane >> amt;
        end
    end

endmodule

// File: rtl/mxn_bits_shift.sv
// mxn_bits_shift: SETS independent WIDTH-bit lanes shifted together, registered output.
// Define MXN_SHIFT_ZERO_FLAG_EN to add the per-lane registered zero_flag output.
module mxn_bits_shift
    import mxn_shift_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int SETS  = 2,
    parameter int OP    = 0
) (
    input logic              clk,
    input logic              rst_n,
    mxn_bits_shift_if.slave  bus
);
    logic [SETS*WIDTH-1:0] shift_d;
    logic [SETS*WIDTH-1:0] out_p1;
`ifdef MXN_SHIFT_ZERO_FLAG_EN
    logic [SETS-1:0]       zero_d;
    logic [SETS-1:0]       zero_p1;
`endif

    for (genvar g = 0; g < SETS; g++) begin : g_lane
        nbits_shift_lane #(
            .WIDTH (WIDTH),
            .OP    (OP)
        ) u_lane (
            .lane   (bus.in_packed[lane_lsb(g, WIDTH) +: WIDTH]),
            .dir    (bus.shift_dir),
            .amt    (bus.shift_amt),
            .result (shift_d[lane_lsb(g, WIDTH) +: WIDTH])
        );
`ifdef MXN_SHIFT_ZERO_FLAG_EN
        assign zero_d[g] = ~|shift_d[lane_lsb(g, WIDTH) +: WIDTH];
`endif
    end

    // Stage p0 -> p1: single output register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_p1 <= '0;
        end else begin
            out_p1 <= shift_d;
        end
    end

    assign bus.out_packed = out_p1;

`ifdef MXN_SHIFT_ZERO_FLAG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_p1 <= '0;
        end else begin
            zero_p1 <= zero_d;
        end
    end

    assign bus.zero_flag = zero_p1;
`endif

endmodule

// File: tb/tb_mxn_bits_shift.sv
// Testbench for mxn_bits_shift: logical and arithmetic instances against an arithmetic model.
module tb_mxn_bits_shift;
    localparam int WIDTH = 4;
    localparam int SETS  = 2;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    mxn_bits_shift_if #(.WIDTH(WIDTH), .SETS(SETS)) bus_l ();
    mxn_bits_shift_if #(.WIDTH(WIDTH), .SETS(SETS)) bus_a ();

    mxn_bits_shift #(.WIDTH(WIDTH), .SETS(SETS), .OP(0)) u_dut_l (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_l)
    );

    mxn_bits_shift #(.WIDTH(WIDTH), .SETS(SETS), .OP(1)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference for one lane: shifts expressed as multiply / floor-divide by powers of two.
    function automatic int model_lane(input int v, input int dir, input int amt, input int op);
        int d, s, q;
        d = 1 << amt;
        if (dir == 0) return (v * d) % 16;
        if (op == 0)  return v / d;
        s = (v >= 8) ? v - 16 : v;
        q = s / d;
        if (s < 0 && (s % d) != 0) q = q - 1;
        return (q + 16) % 16;
    endfunction

    function automatic int model_bus(input int in, input int dir, input int amt, input int op);
        int r = 0;
        for (int i = 0; i < SETS; i++)
            r += model_lane((in / (16 ** i)) % 16, dir, amt, op) * (16 ** i);
        return r;
    endfunction

    function automatic int model_zero(input int in, input int dir, input int amt, input int op);
        int z = 0;
        for (int i = 0; i < SETS; i++)
            if (model_lane((in / (16 ** i)) % 16, dir, amt, op) == 0) z += (1 << i);
        return z;
    endfunction

    task automatic drive(input logic [7:0] in, input logic dir, input logic [3:0] amt);
        bus_l.in_packed = in;  bus_l.shift_dir = dir;  bus_l.shift_amt = amt;
        bus_a.in_packed = in;  bus_a.shift_dir = dir;  bus_a.shift_amt = amt;
    endtask

    task automatic apply(input string tag, input logic [7:0] in, input logic dir, input logic [3:0] amt);
        @(negedge clk);
        drive(in, dir, amt);
        @(posedge clk);
        #1;
        check({tag, "_lo"}, 32'(bus_l.out_packed), 32'(model_bus(int'(in), int'(dir), int'(amt), 0)));
        check({tag, "_ar"}, 32'(bus_a.out_packed), 32'(model_bus(int'(in), int'(dir), int'(amt), 1)));
`ifdef MXN_SHIFT_ZERO_FLAG_EN
        check({tag, "_zf_lo"}, 32'(bus_l.zero_flag), 32'(model_zero(int'(in), int'(dir), int'(amt), 0)));
        check({tag, "_zf_ar"}, 32'(bus_a.zero_flag), 32'(model_zero(int'(in), int'(dir), int'(amt), 1)));
`endif
    endtask

    initial begin
        logic [7:0] rin;
        logic       rdir;
        logic [3:0] ramt;

        rst_n = 1'b0;
        drive(8'h93, 1'b0, 4'd1);
        #12;
        check("reset_lo", 32'(bus_l.out_packed), 32'h0);
        check("reset_ar", 32'(bus_a.out_packed), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        apply("left", 8'b1001_0011, 1'b0, 4'd1);
        check("left_const_lo", 32'(bus_l.out_packed), 32'b0010_0110);
        check("left_const_ar", 32'(bus_a.out_packed), 32'b0010_0110);

        apply("right", 8'b1000_0110, 1'b1, 4'd2);
        check("right_const_lo", 32'(bus_l.out_packed), 32'b0010_0001);
        check("right_const_ar", 32'(bus_a.out_packed), 32'b1110_0001);

        apply("amt0", 8'b1011_0101, 1'b1, 4'd0);
        check("amt0_const_lo", 32'(bus_l.out_packed), 32'b1011_0101);
        check("amt0_const_ar", 32'(bus_a.out_packed), 32'b1011_0101);

        apply("amt5", 8'b1011_1011, 1'b1, 4'd5);
        check("amt5_const_lo", 32'(bus_l.out_packed), 32'h00);
        check("amt5_const_ar", 32'(bus_a.out_packed), 32'hff);

`ifdef MXN_SHIFT_ZERO_FLAG_EN
        apply("zflag", 8'b1000_0001, 1'b0, 4'd1);
        check("zflag_const", 32'(bus_l.zero_flag), 32'b10);
`endif

        // Asynchronous reset asserted mid-cycle while the outputs are nonzero.
        apply("pre_rst", 8'b0111_0101, 1'b0, 4'd1);
        @(negedge clk);
        drive(8'b1100_0110, 1'b1, 4'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_lo", 32'(bus_l.out_packed), 32'h0);
        check("async_rst_ar", 32'(bus_a.out_packed), 32'h0);
        @(posedge clk);
        #1;
        check("rst_held_lo", 32'(bus_l.out_packed), 32'h0);
        check("rst_held_ar", 32'(bus_a.out_packed), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_lo", 32'(bus_l.out_packed), 32'(model_bus(8'b1100_0110, 1, 1, 0)));
        check("post_rst_ar", 32'(bus_a.out_packed), 32'(model_bus(8'b1100_0110, 1, 1, 1)));

        // Every lane value with the listed direction / amount pairs.
        for (int v = 0; v < 16; v++) begin
            for (int a = 1; a <= 3; a++)
                apply("sweep_l", 8'((v << 4) | (15 - v)), 1'b0, 4'(a));
            for (int a = 1; a <= 2; a++)
                apply("sweep_r", 8'((v << 4) | (15 - v)), 1'b1, 4'(a));
        end

        for (int n = 0; n < 300; n++) begin
            rin  = 8'($urandom_range(255));
            rdir = 1'($urandom_range(1));
            ramt = 4'($urandom_range(15));
            apply("rand", rin, rdir, ramt);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
